// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - serial command responder: sends a selected code byte as a start/8-data/stop frame
// Outputs are registered so start and command never reach tx, ready_command or done combinationally.
module cmd_responder #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter logic [7:0]  CMD0         = 8'h41,
   parameter logic [7:0]  CMD1         = 8'h42
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic command,
   output logic ready_command,
   output logic tx,
   output logic done
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA,
      STOP_BIT
   } state_t;

   state_t          state;
   logic [CW-1:0]   clk_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      code;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         clk_cnt       <= '0;
         bit_idx       <= '0;
         code          <= '0;
         tx            <= 1'b1;
         ready_command <= 1'b1;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx            <= 1'b1;
               ready_command <= 1'b1;
               clk_cnt       <= '0;
               bit_idx       <= '0;
               if (start) begin
                  code          <= command ? CMD1 : CMD0;
                  state         <= START_BIT;
                  tx            <= 1'b0;
                  ready_command <= 1'b0;
               end
            end
            START_BIT: begin
               if (clk_cnt == LAST_CLK) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= code[0];
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt == LAST_CLK) begin
                  clk_cnt <= '0;
                  // Index stops at 7; the stop bit follows instead of a wrap to bit 0.
                  if (bit_idx == 3'd7) begin
                     state <= STOP_BIT;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= code[bit_idx + 3'd1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP_BIT: begin
               if (clk_cnt == LAST_CLK) begin
                  clk_cnt       <= '0;
                  state         <= IDLE;
                  tx            <= 1'b1;
                  ready_command <= 1'b1;
                  done          <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               tx            <= 1'b1;
               ready_command <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_responder.sv
// tb/tb_cmd_responder.sv - directed and random checks of cmd_responder against a frame-position model
// The model tracks only "in frame / position in frame / byte"; tx is derived from the position.
module tb_cmd_responder;

   localparam int CPB       = 4;
   localparam int FRAME_LEN = 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic command = 1'b0;
   logic ready_command;
   logic tx;
   logic done;

   int vectors = 0;
   int miscompares = 0;

   bit         m_active = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_byte = 8'h00;
   bit         m_done = 1'b0;

   always #5 clk = ~clk;

   cmd_responder #(
      .CLKS_PER_BIT(CPB),
      .CMD0        (8'h41),
      .CMD1        (8'h42)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .command      (command),
      .ready_command(ready_command),
      .tx           (tx),
      .done         (done)
   );

   function automatic logic model_tx();
      int slot;
      if (!m_active) return 1'b1;
      slot = m_pos / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_byte[slot-1];
      return 1'b1;
   endfunction

   task automatic check_outputs();
      logic e_tx;
      logic e_rdy;
      logic e_done;
      e_tx   = model_tx();
      e_rdy  = !m_active;
      e_done = m_done;
      vectors++;
      assert (tx === e_tx) else begin
         miscompares++;
         $error("FAIL tx t=%0t got %b expected %b", $time, tx, e_tx);
      end
      assert (ready_command === e_rdy) else begin
         miscompares++;
         $error("FAIL ready_command t=%0t got %b expected %b", $time, ready_command, e_rdy);
      end
      assert (done === e_done) else begin
         miscompares++;
         $error("FAIL done t=%0t got %b expected %b", $time, done, e_done);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply inputs, clock once, advance the model, then check just after the edge.
   task automatic step(input logic r, input logic s, input logic c);
      rst = r;
      start = s;
      command = c;
      @(posedge clk);
      m_done = 1'b0;
      if (r) begin
         m_active = 1'b0;
         m_byte   = 8'h00;
      end else if (m_active) begin
         if (m_pos == FRAME_LEN - 1) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end else begin
            m_pos++;
         end
      end else if (s) begin
         m_active = 1'b1;
         m_pos    = 0;
         m_byte   = c ? 8'h42 : 8'h41;
      end
      #1;
      check_outputs();
   endtask

   initial begin
      logic [9:0] pat;
      int done_at;
      int done_first;
      int done_second;

      // Reset, then a quiet idle line.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

      // Single CMD0 frame: sample the middle of each bit and locate done.
      pat = {1'b1, 8'h41, 1'b0};
      done_at = -1;
      step(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 45; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if ((i % CPB) == 1 && (i / CPB) < 10)
            check_int($sformatf("cmd0_bit%0d", i / CPB), int'(tx), int'(pat[i / CPB]));
         if (done === 1'b1 && done_at < 0) done_at = i;
      end
      check_int("cmd0_done_offset", done_at, FRAME_LEN);

      // CMD1 frame with command toggling throughout.
      step(1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, logic'(i % 2));

      // start held high: back-to-back frames, done spacing.
      done_first = -1;
      done_second = -1;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (done === 1'b1) begin
            if (done_first < 0) done_first = i;
            else if (done_second < 0) done_second = i;
         end
      end
      check_int("b2b_done_spacing", done_second - done_first, FRAME_LEN + 1);
      for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 1'b0);

      // Reset during data bit 3, then a clean frame.
      step(1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 17; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check_int("abort_tx", int'(tx), 1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, 1'b0);

      // Ten 10-cycle start bursts at 40-cycle spacing.
      for (int p = 0; p < 10; p++) begin
         for (int i = 0; i < 10; i++) step(1'b0, 1'b1, logic'(p % 2));
         for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 1'b0);

      // Release reset with start already high.
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_int("accept_after_reset", int'(ready_command), 0);
      for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, 1'b0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++)
         step(logic'($urandom_range(0, 199) == 0),
              logic'($urandom_range(0, 3) == 0),
              logic'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
